enemy_fire_sched: RTL and testbench

//  Upstream of the per-enemy missile controllers: decides when, and from which enemy, the next shot leaves.

---
 rtl/enemy_fire_sched_if.sv | 22 ++
 rtl/enemy_fire_sched.sv | 123 ++++++++++++
 tb/tb_enemy_fire_sched.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/enemy_fire_sched_if.sv
// Signal bundle between the enemy fire scheduler and the game / missile-controller side.
interface enemy_fire_sched_if #(
  parameter int N_ENEMIES = 8,
  parameter int IDX_W     = 3
);
  logic                 enable;
  logic [N_ENEMIES-1:0] enemy_lives;
  logic [N_ENEMIES-1:0] missile_on;
  logic [N_ENEMIES-1:0] fire;
  logic [IDX_W-1:0]     fire_idx;
  logic [15:0]          shots_fired;

  modport master (
    output enable, enemy_lives, missile_on,
    input  fire, fire_idx, shots_fired
  );

  modport slave (
    input  enable, enemy_lives, missile_on,
    output fire, fire_idx, shots_fired
  );
endinterface

// File: rtl/enemy_fire_sched.sv
// Enemy fire scheduler: waits an LFSR-randomised interval, then scans the formation round-robin for a
// live enemy with no missile in flight and pulses that enemy's fire line for one cycle.
//
// state | meaning
// IDLE  | game stopped; no timer running, fire held low
// WAIT  | interval (or retry) timer counting down to the next scan
// PICK  | testing one candidate enemy per cycle
// FIRE  | fire pulse on the output; reload the interval timer
module enemy_fire_sched #(
  parameter int          N_ENEMIES      = 8,
  parameter int          IDX_W          = 3,
  parameter int unsigned INTERVAL_BASE  = 3_250_000,
  parameter int unsigned INTERVAL_SHIFT = 14,
  parameter int unsigned RETRY_TICKS    = 65_000,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input logic               pclk,
  input logic               rst,
  enemy_fire_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    PICK = 2'd2,
    FIRE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [15:0]          lfsr_q;
  logic [15:0]          lfsr_next;
  logic [23:0]          timer_q, timer_d;
  logic [23:0]          reload_val;
  logic [IDX_W-1:0]     cand_q, cand_d;
  logic [IDX_W-1:0]     scan_q, scan_d;
  logic [N_ENEMIES-1:0] fire_q, fire_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [15:0]          shots_q, shots_d;
  logic                 cand_ok;
  logic                 scan_last;

  // Galois LFSR free-runs every cycle, independent of state and enable
  assign lfsr_next  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign reload_val = 24'(INTERVAL_BASE) + (24'(lfsr_q[7:0]) << INTERVAL_SHIFT);
  assign cand_ok    = bus.enemy_lives[cand_q] && !bus.missile_on[cand_q];
  assign scan_last  = (scan_q == IDX_W'(N_ENEMIES - 1));

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cand_d  = cand_q;
    scan_d  = scan_q;
    fire_d  = '0;
    idx_d   = idx_q;
    shots_d = shots_q;
    if (!bus.enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          timer_d = reload_val;
          state_d = WAIT;
        end
        WAIT: begin
          if (timer_q == 24'd0) begin
            cand_d  = lfsr_q[IDX_W-1:0];
            scan_d  = '0;
            state_d = PICK;
          end else begin
            timer_d = timer_q - 24'd1;
          end
        end
        PICK: begin
          // count and index are committed with the pulse so all three outputs agree in FIRE
          if (cand_ok) begin
            fire_d[cand_q] = 1'b1;
            idx_d          = cand_q;
            shots_d        = shots_q + 16'd1;
            state_d        = FIRE;
          end else if (scan_last) begin
            timer_d = 24'(RETRY_TICKS);
            state_d = WAIT;
          end else begin
            cand_d = cand_q + 1'b1;
            scan_d = scan_q + 1'b1;
          end
        end
        FIRE: begin
          timer_d = reload_val;
          state_d = WAIT;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q  <= LFSR_SEED;
      timer_q <= '0;
      cand_q  <= '0;
      scan_q  <= '0;
      fire_q  <= '0;
      idx_q   <= '0;
      shots_q <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_next;
      timer_q <= timer_d;
      cand_q  <= cand_d;
      scan_q  <= scan_d;
      fire_q  <= fire_d;
      idx_q   <= idx_d;
      shots_q <= shots_d;
    end
  end

  assign bus.fire        = fire_q;
  assign bus.fire_idx    = idx_q;
  assign bus.shots_fired = shots_q;

endmodule

// File: tb/tb_enemy_fire_sched.sv
// Randomised bench for enemy_fire_sched; a timeline model (absolute cycle deadlines) predicts every output.
module tb_enemy_fire_sched;
  localparam int          N      = 8;
  localparam int          IDX_W  = 3;
  localparam int          BASE   = 8;
  localparam int          SHIFT  = 0;
  localparam int          RETRY  = 4;
  localparam logic [15:0] SEED   = 16'hACE1;

  logic pclk = 1'b0;
  logic rst  = 1'b1;

  enemy_fire_sched_if #(.N_ENEMIES(N), .IDX_W(IDX_W)) bus ();

  enemy_fire_sched #(
    .N_ENEMIES(N), .IDX_W(IDX_W), .INTERVAL_BASE(BASE), .INTERVAL_SHIFT(SHIFT),
    .RETRY_TICKS(RETRY), .LFSR_SEED(SEED)
  ) dut (
    .pclk(pclk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic longint reload_of(input logic [15:0] v);
    return longint'(BASE) + (longint'(v[7:0]) << SHIFT);
  endfunction

  // Model: absolute edge numbers for when the interval is armed, when the scan starts, and which PICK edges test whom.
  longint           cyc, arm_at, decide_at, last_reload;
  int               start_cand, k, cand;
  bit               armed, wrap_now;
  bit               preload_req = 1'b0;
  bit               chk_en      = 1'b0;
  logic [N-1:0]     m_fire, prev_fire;
  logic [IDX_W-1:0] m_idx;
  logic [15:0]      m_lfsr, m_shots;

  always @(posedge pclk or posedge rst or posedge preload_req) begin
    if (rst) begin
      cyc = 0; arm_at = -1; decide_at = -1; last_reload = 0; start_cand = 0;
      armed = 0; wrap_now = 0; m_fire = '0; m_idx = '0; m_lfsr = SEED; m_shots = '0;
    end else if (preload_req) begin
      m_shots = 16'hFFFF;
    end else begin
      cyc++;
      m_fire   = '0;
      wrap_now = 0;
      if (!bus.enable) begin
        armed = 0; arm_at = -1; decide_at = -1;
      end else begin
        if (!armed) begin
          armed  = 1;
          arm_at = cyc;
        end
        if (cyc == arm_at) begin
          last_reload = reload_of(m_lfsr);
          decide_at   = cyc + last_reload + 1;
          arm_at      = -1;
        end else if (cyc == decide_at) begin
          start_cand = int'(m_lfsr[IDX_W-1:0]);
        end else if (decide_at >= 0 && cyc > decide_at && cyc <= decide_at + N) begin
          k    = int'(cyc - decide_at - 1);
          cand = (start_cand + k) % N;
          if (bus.enemy_lives[cand] && !bus.missile_on[cand]) begin
            m_fire[cand] = 1'b1;
            m_idx        = IDX_W'(cand);
            m_shots      = m_shots + 16'd1;
            wrap_now     = (start_cand == N - 1) && (cand == 0);
            arm_at       = cyc + 1;
            decide_at    = -1;
          end else if (k == N - 1) begin
            decide_at = cyc + RETRY + 1;
          end
        end
      end
      m_lfsr = lfsr_step(m_lfsr);
    end
  end

  always @(negedge pclk) begin
    if (chk_en && !rst) begin
      chk(bus.fire === m_fire, "fire", bus.fire, m_fire);
      chk(bus.fire_idx === m_idx, "fire_idx", bus.fire_idx, m_idx);
      chk(bus.shots_fired === m_shots, "shots_fired", bus.shots_fired, m_shots);
      chk($countones(bus.fire) <= 1, "fire_onehot", $countones(bus.fire), 1);
      chk(!(prev_fire != '0 && bus.fire != '0), "fire_back_to_back", bus.fire, 0);
      prev_fire = bus.fire;
    end else begin
      prev_fire = '0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic wait_fire(input int limit, output int n, output bit got);
    n = 0; got = 0;
    while (n < limit && !got) begin
      @(posedge pclk); #1;
      n++;
      if (bus.fire != '0) got = 1;
    end
  endtask

  int          n, fires;
  bit          got;
  longint      r0;
  logic [15:0] v, saved;

  initial begin
    bus.enable = 1'b0; bus.enemy_lives = '0; bus.missile_on = '0;

    // pin the reference model itself
    chk(lfsr_step(16'hACE1) == 16'hE270, "model_lfsr_step", lfsr_step(16'hACE1), 16'hE270);
    v = 16'hACE1;
    repeat (6) v = lfsr_step(v);
    chk(v == 16'hB313, "model_lfsr_6steps", v, 16'hB313);
    chk(reload_of(16'h12FF) == 263, "model_reload", reload_of(16'h12FF), 263);

    repeat (3) @(posedge pclk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    chk(bus.fire == '0, "reset_fire", bus.fire, 0);
    chk(bus.fire_idx == '0, "reset_idx", bus.fire_idx, 0);
    chk(bus.shots_fired == 16'd0, "reset_shots", bus.shots_fired, 0);

    // idle: enable low, nothing fires
    fires = 0;
    repeat (1000) begin
      @(posedge pclk); #1;
      if (bus.fire != '0) fires++;
    end
    chk(fires == 0, "idle_no_fire", fires, 0);
    chk(bus.shots_fired == 16'd0, "idle_shots", bus.shots_fired, 0);

    // first shot latency against the reference LFSR
    bus.enemy_lives = 8'hFF; bus.missile_on = '0; bus.enable = 1'b1;
    @(posedge pclk); #1;
    r0 = last_reload;
    wait_fire(400, n, got);
    n++;
    chk(got, "first_fire_timeout", got, 1);
    chk(n >= r0 + 2 && n <= r0 + 3, "first_fire_latency", n, r0 + 3);
    chk(int'(bus.fire_idx) == start_cand, "first_fire_idx", bus.fire_idx, start_cand);
    @(posedge pclk); #1;
    chk(bus.fire == '0, "pulse_width", bus.fire, 0);
    repeat (3) begin
      wait_fire(400, n, got);
      chk(got, "more_fire_timeout", got, 1);
    end

    // async reset in the middle of a wait
    repeat (5) @(posedge pclk);
    #3 rst = 1'b1;
    #1;
    chk(bus.fire == '0, "async_rst_fire", bus.fire, 0);
    chk(bus.fire_idx == '0, "async_rst_idx", bus.fire_idx, 0);
    chk(bus.shots_fired == 16'd0, "async_rst_shots", bus.shots_fired, 0);
    @(posedge pclk); #1 rst = 1'b0;

    // skip rule: only enemy 2 alive
    bus.enemy_lives = 8'b0000_0100;
    repeat (5) begin
      wait_fire(600, n, got);
      chk(got && bus.fire == 8'h04, "skip_only_bit2", bus.fire, 8'h04);
    end
    bus.missile_on = 8'b0000_0100;
    saved = bus.shots_fired;
    fires = 0;
    repeat (600) begin
      @(posedge pclk); #1;
      if (bus.fire != '0) fires++;
    end
    chk(fires == 0, "busy_no_fire", fires, 0);
    chk(bus.shots_fired == saved, "busy_shots", bus.shots_fired, saved);

    // wrap scan: start candidate 7, only enemy 0 alive
    bus.enemy_lives = 8'b0000_0001; bus.missile_on = '0;
    got = 0; n = 0;
    while (!got && n < 30000) begin
      @(posedge pclk); #1;
      n++;
      if (wrap_now) got = 1;
    end
    chk(got, "wrap_timeout", got, 1);
    chk(bus.fire == 8'h01, "wrap_fire", bus.fire, 8'h01);
    chk(bus.fire_idx == 3'd0, "wrap_idx", bus.fire_idx, 0);

    // enable dropped in the accepting PICK cycle
    bus.enemy_lives = 8'hFF;
    got = 0; n = 0;
    while (!got && n < 600) begin
      @(posedge pclk); #1;
      n++;
      if (decide_at >= 0 && cyc == decide_at) got = 1;
    end
    chk(got, "drop_wait_timeout", got, 1);
    saved = bus.shots_fired;
    bus.enable = 1'b0;
    @(posedge pclk); #1;
    chk(bus.fire == '0, "drop_no_pulse", bus.fire, 0);
    chk(bus.shots_fired == saved, "drop_shots", bus.shots_fired, saved);
    repeat (2) @(posedge pclk);
    #1 bus.enable = 1'b1;
    @(posedge pclk); #1;
    r0 = last_reload;
    wait_fire(400, n, got);
    n++;
    chk(got && n == r0 + 3, "drop_restart_latency", n, r0 + 3);

    // counter wrap via preload
    @(posedge pclk); #1;
    force dut.shots_q = 16'hFFFF;
    preload_req = 1'b1;
    #1;
    release dut.shots_q;
    preload_req = 1'b0;
    chk(bus.shots_fired == 16'hFFFF, "preload", bus.shots_fired, 16'hFFFF);
    wait_fire(400, n, got);
    chk(got, "wrap_shot_timeout", got, 1);
    chk(bus.shots_fired == 16'd0, "shots_wrap", bus.shots_fired, 0);

    // random traffic
    fires = 0;
    for (int i = 0; i < 15000; i++) begin
      @(posedge pclk); #1;
      if (bus.fire != '0) fires++;
      if (bus.enable && $urandom_range(0, 299) == 0) bus.enable = 1'b0;
      else if (!bus.enable && $urandom_range(0, 3) == 0) bus.enable = 1'b1;
      if ($urandom_range(0, 15) == 0) bus.enemy_lives = N'($urandom);
      if ($urandom_range(0, 60) == 0) bus.enemy_lives = '0;
      bus.missile_on = N'($urandom & $urandom & $urandom);
    end
    chk(fires > 10, "random_activity", fires, 11);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
